// File: rtl/tc_ram_multi_port.sv
// Multi-read-port RAM with one byte-masked write port, registered read ports
// with per-port valid, selectable read-during-write and a post-reset clear sequencer.
module tc_ram_multi_port #(
    parameter int WORD_WIDTH     = 16,
    parameter int WORD_COUNT     = 256,
    parameter int READ_PORTS     = 2,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               save,
    input  logic [32:0]                        save_address,
    input  logic [WORD_WIDTH-1:0]              in,
    input  logic [WORD_WIDTH/BYTE_WIDTH-1:0]   save_mask,
    input  logic [READ_PORTS-1:0]              load,
    input  logic [READ_PORTS*33-1:0]           address,
    output logic [READ_PORTS*WORD_WIDTH-1:0]   out,
    output logic [READ_PORTS-1:0]              valid,
    output logic                               busy
);

    localparam int              MASK_W = WORD_WIDTH / BYTE_WIDTH;
    localparam int              AW     = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [32:0]     LIMIT  = 33'(WORD_COUNT);
    localparam logic [AW-1:0]   LAST   = AW'(WORD_COUNT - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_e;

    function automatic logic [WORD_WIDTH-1:0] merge_bytes(
        input logic [WORD_WIDTH-1:0] old_word,
        input logic [WORD_WIDTH-1:0] new_word,
        input logic [MASK_W-1:0]     mask
    );
        logic [WORD_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < MASK_W; k++) begin
            if (mask[k]) begin
                res[k*BYTE_WIDTH +: BYTE_WIDTH] = new_word[k*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                res[k*BYTE_WIDTH +: BYTE_WIDTH] = old_word[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    logic [WORD_WIDTH-1:0]            mem [WORD_COUNT];
    state_e                           state_q, state_d;
    logic [AW-1:0]                    cnt_q, cnt_d;
    logic                             busy_q, busy_d;
    logic [READ_PORTS*WORD_WIDTH-1:0] out_q, out_d;
    logic [READ_PORTS-1:0]            valid_q, valid_d;

    logic                             ready_s;
    logic                             save_ok_s;
    logic [AW-1:0]                    save_idx_s;
    logic [WORD_WIDTH-1:0]            save_word_s;
    logic                             mem_we_s;
    logic [AW-1:0]                    mem_waddr_s;
    logic [WORD_WIDTH-1:0]            mem_wdata_s;

    // Sequencer next state: reset holds, clear walks the array once, then ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b1;
        if (!rst) begin
            state_d = ST_RESET;
            cnt_d   = {AW{1'b0}};
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
                    cnt_d   = {AW{1'b0}};
                end
                ST_CLEAR: begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == LAST) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
                ST_READY: begin
                    state_d = ST_READY;
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = {AW{1'b0}};
                end
            endcase
            busy_d = (state_d != ST_READY);
        end
    end

    // Write port: clear writes take priority; user writes only when ready and in range.
    always_comb begin
        ready_s     = rst && (state_q == ST_READY);
        save_ok_s   = save && (save_address < LIMIT);
        save_idx_s  = save_address[AW-1:0];
        save_word_s = merge_bytes(mem[save_idx_s], in, save_mask);
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_q;
        mem_wdata_s = {WORD_WIDTH{1'b0}};
        if (rst && (state_q == ST_CLEAR)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_q;
            mem_wdata_s = {WORD_WIDTH{1'b0}};
        end else if (ready_s && save_ok_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = save_idx_s;
            mem_wdata_s = save_word_s;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Read ports; a same-address write is forwarded only in write-first mode.
    always_comb begin
        out_d   = {(READ_PORTS*WORD_WIDTH){1'b0}};
        valid_d = {READ_PORTS{1'b0}};
        for (int p = 0; p < READ_PORTS; p++) begin
            if (ready_s && load[p]) begin
                valid_d[p] = 1'b1;
                if (address[p*33 +: 33] < LIMIT) begin
                    if ((READ_MODE != 0) && save_ok_s && (address[p*33 +: 33] == save_address)) begin
                        out_d[p*WORD_WIDTH +: WORD_WIDTH] = save_word_s;
                    end else begin
                        out_d[p*WORD_WIDTH +: WORD_WIDTH] = mem[address[p*33 +: AW]];
                    end
                end else begin
                    out_d[p*WORD_WIDTH +: WORD_WIDTH] = {WORD_WIDTH{1'b0}};
                end
            end else begin
                valid_d[p] = 1'b0;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RESET;
            cnt_q   <= {AW{1'b0}};
            busy_q  <= 1'b1;
            out_q   <= {(READ_PORTS*WORD_WIDTH){1'b0}};
            valid_q <= {READ_PORTS{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // Storage array; not reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: doc/tc_ram_multi_port.md
# tc_ram_multi_port

Parametrised multi-read-port RAM: the next generation of the dual-load RAM components in the component library. It provides one byte-masked write port, READ_PORTS independent registered read ports with per-port valid, selectable read-during-write behaviour, and a hardware clear sequencer that zeroes the array one word per cycle after reset. It sits wherever the generated design needs a register-file or scratch memory with more than two concurrent readers.

## Interface
- WORD_WIDTH, 16, data width in bits; must be a multiple of BYTE_WIDTH.
- WORD_COUNT, 256, number of words; valid addresses are 0..WORD_COUNT-1.
- READ_PORTS, 2, number of read ports, 1..8.
- BYTE_WIDTH, 8, write-mask granularity; MASK_W = WORD_WIDTH/BYTE_WIDTH.
- READ_MODE, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = leave the array untouched.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- save  input  1  write request.
- save_address  input  33  write address.
- in  input  WORD_WIDTH  write data.
- save_mask  input  MASK_W  per-byte write enable; bit k covers in[k*BYTE_WIDTH +: BYTE_WIDTH].
- load  input  READ_PORTS  per-port read request.
- address  input  READ_PORTS*33  packed read addresses; port p uses [p*33 +: 33].
- out  output  READ_PORTS*WORD_WIDTH  packed registered read data; port p uses [p*WORD_WIDTH +: WORD_WIDTH].
- valid  output  READ_PORTS  per-port read-data-valid.
- busy  output  1  high during reset and the clear sequence; all requests are ignored while high.

## Operation
- States: RESET (rst=0), CLEAR, READY. The state, busy, out and valid are registered.
- At an edge with rst=0: out=0, valid=0, busy=1, clear counter=0, state RESET. The array is not written at that edge.
- RESET -> CLEAR at the first edge with rst=1 if CLEAR_ON_RESET=1. Otherwise RESET -> READY.
- CLEAR: at each edge, writes zero to mem[counter] and increments counter. After the edge that clears word WORD_COUNT-1, the state becomes READY and busy falls.
- Reset asserted mid-CLEAR restarts the sequence from word 0. Words already cleared stay zero.
- While busy=1 at an edge: save is dropped, and every port registers out=0, valid=0.
- READY write: if save=1 and save_address<WORD_COUNT, byte k of mem[save_address] takes in byte k for every set save_mask bit; other bytes keep their value. An out-of-range write, or save_mask=0, changes nothing.
- READY read, port p: if load[p]=1, out_p<=mem[addr_p] and valid[p]<=1. An out-of-range address gives out_p<=0 with valid[p]<=1. If load[p]=0, out_p<=0 and valid[p]<=0.
- Collision, same-edge write and read to the same in-range address:
  - READ_MODE=0: the read returns the pre-write word.
  - READ_MODE=1: the read returns the post-merge word.
  - Every colliding port behaves identically. Ports reading the same address without a write all return the same word.

## Timing
- Read latency is 1 cycle: request sampled at edge t, data and valid visible after edge t.
- A write sampled at edge t is visible to reads sampled at edge t+1 regardless of READ_MODE.
- Clear duration: busy=1 for exactly WORD_COUNT cycles after reset release when CLEAR_ON_RESET=1, and for 0 cycles otherwise. The first accepted request is at the edge where busy is already 0.
- Reset values: out=0, valid=0, busy=1.
- Throughput: one write plus READ_PORTS reads per cycle, with no stalls in READY.

## Test plan
- Reset and clear (WORD_COUNT=16, CLEAR_ON_RESET=1): hold rst=0 for 2 edges, then release. Required: busy=1 for exactly 16 cycles after release; then a read of every address returns 0x0000 with valid=1.
- Byte mask: write 0xABCD with mask 2'b11 to addr 5, then 0x1200 with mask 2'b10 to addr 5, then read addr 5 on port 0. Required: port 0 returns 0x12CD one cycle after the read request.
- Collision: mem[3]=0x1111; write 0x2222 to addr 3 and read addr 3 on ports 0 and 1 at the same edge. Required: both ports return 0x1111 with READ_MODE=0, and 0x2222 with READ_MODE=1.
- Out of range (WORD_COUNT=16): write 0xFFFF to addr 16, then read addr 16 and addr 0. Required: both reads return 0x0000 with valid=1; no word is modified.
- Mid-clear reset: assert rst=0 for 1 edge at clear cycle 7 with all words preloaded to 0x5555 using CLEAR_ON_RESET=0, then rebuild with CLEAR_ON_RESET=1 and repeat. Required: the clear sequence restarts, busy lasts 16 further cycles, all words read back 0, and requests issued while busy return valid=0 and out=0.
